// File: rtl/fantasticfft_ifft8.sv
// Iterative 8-point radix-2 DIT inverse FFT, the decode side of fantasticfft FFT8.
// Serial load into bit-reversed RAM, 12 single-butterfly cycles, natural-order unload.
module fantasticfft_ifft8 #(
    parameter int WI = 8,
    parameter int WF = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WI+WF-1:0]   in_re,
    input  logic [WI+WF-1:0]   in_im,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WI+WF-1:0]   out_re,
    output logic [WI+WF-1:0]   out_im,
    output logic               out_last,
    output logic               busy
);

    localparam int W = WI + WF;
    localparam int P = 2 * W;

    localparam logic [W-1:0] TwZero   = '0;
    localparam logic [W-1:0] TwOne    = W'(1 << WF);
    localparam logic [W-1:0] TwC45    = W'((181 << WF) >> 8);
    localparam logic [W-1:0] TwNegC45 = (~TwC45) + W'(1);

    typedef enum logic [1:0] {
        StLoad,
        StCompute,
        StUnload
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [W-1:0] ram_re [8];
    logic [W-1:0] ram_im [8];
    logic [W-1:0] out_re_q, out_im_q;

    logic         in_hs, out_hs;
    logic [2:0]   load_addr;

    assign in_ready  = (state_q == StLoad);
    assign out_valid = (state_q == StUnload);
    assign out_last  = out_valid && (cnt_q == 4'd7);
    assign busy      = (state_q != StLoad);
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;

    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign load_addr = {cnt_q[0], cnt_q[1], cnt_q[2]};

    // Control: one counter serves as load count, butterfly index and unload index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLoad;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StLoad: begin
                if (in_hs) begin
                    if (cnt_q == 4'd7) begin
                        state_d = StCompute;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StCompute: begin
                if (cnt_q == 4'd11) begin
                    state_d = StUnload;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StUnload: begin
                if (out_hs) begin
                    if (cnt_q == 4'd7) begin
                        state_d = StLoad;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = StLoad;
                cnt_d   = '0;
            end
        endcase
    end

    // Butterfly addressing: stage = cnt[3:2], butterfly = cnt[1:0].
    logic [1:0] stage, bf, tw_k;
    logic [2:0] addr_a, addr_b;

    always_comb begin
        stage  = cnt_q[3:2];
        bf     = cnt_q[1:0];
        addr_a = {bf, 1'b0};
        addr_b = {bf, 1'b1};
        tw_k   = 2'd0;
        case (stage)
            2'd1: begin
                addr_a = {bf[1], 1'b0, bf[0]};
                addr_b = {bf[1], 1'b1, bf[0]};
                tw_k   = {bf[0], 1'b0};
            end
            2'd2: begin
                addr_a = {1'b0, bf};
                addr_b = {1'b1, bf};
                tw_k   = bf;
            end
            default: ;
        endcase
    end

    // Inverse twiddles exp(+j*2*pi*k/8).
    logic [W-1:0] w_re, w_im;

    always_comb begin
        w_re = TwOne;
        w_im = TwZero;
        case (tw_k)
            2'd1: begin
                w_re = TwC45;
                w_im = TwC45;
            end
            2'd2: begin
                w_re = TwZero;
                w_im = TwOne;
            end
            2'd3: begin
                w_re = TwNegC45;
                w_im = TwC45;
            end
            default: ;
        endcase
    end

    // Datapath: low P bits of a sign-extended product equal the signed product.
    logic [W-1:0] a_re, a_im, b_re, b_im;
    logic [P-1:0] b_re_x, b_im_x, w_re_x, w_im_x;
    logic [P-1:0] p_rr, p_ii, p_ri, p_ir;
    logic [P:0]   t_re_full, t_im_full;
    logic [W-1:0] t_re, t_im;
    logic [W:0]   sum_re, sum_im, dif_re, dif_im;
    logic [W-1:0] na_re, na_im, nb_re, nb_im;

    always_comb begin
        a_re   = ram_re[addr_a];
        a_im   = ram_im[addr_a];
        b_re   = ram_re[addr_b];
        b_im   = ram_im[addr_b];
        b_re_x = {{W{b_re[W-1]}}, b_re};
        b_im_x = {{W{b_im[W-1]}}, b_im};
        w_re_x = {{W{w_re[W-1]}}, w_re};
        w_im_x = {{W{w_im[W-1]}}, w_im};
        p_rr   = b_re_x * w_re_x;
        p_ii   = b_im_x * w_im_x;
        p_ri   = b_re_x * w_im_x;
        p_ir   = b_im_x * w_re_x;
        t_re_full = {p_rr[P-1], p_rr} - {p_ii[P-1], p_ii};
        t_im_full = {p_ri[P-1], p_ri} + {p_ir[P-1], p_ir};
        // Arithmetic shift right by WF then keep the low W bits.
        t_re   = W'(t_re_full >> WF);
        t_im   = W'(t_im_full >> WF);
        sum_re = {a_re[W-1], a_re} + {t_re[W-1], t_re};
        sum_im = {a_im[W-1], a_im} + {t_im[W-1], t_im};
        dif_re = {a_re[W-1], a_re} - {t_re[W-1], t_re};
        dif_im = {a_im[W-1], a_im} - {t_im[W-1], t_im};
        na_re  = W'(sum_re >> 1);
        na_im  = W'(sum_im >> 1);
        nb_re  = W'(dif_re >> 1);
        nb_im  = W'(dif_im >> 1);
    end

    // Sample RAM and registered output sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                ram_re[i] <= '0;
                ram_im[i] <= '0;
            end
            out_re_q <= '0;
            out_im_q <= '0;
        end else begin
            case (state_q)
                StLoad: begin
                    if (in_hs) begin
                        ram_re[load_addr] <= in_re;
                        ram_im[load_addr] <= in_im;
                    end
                end
                StCompute: begin
                    ram_re[addr_a] <= na_re;
                    ram_im[addr_a] <= na_im;
                    ram_re[addr_b] <= nb_re;
                    ram_im[addr_b] <= nb_im;
                    // The last butterfly touches 3 and 7, so RAM[0] is already final.
                    if (cnt_q == 4'd11) begin
                        out_re_q <= ram_re[0];
                        out_im_q <= ram_im[0];
                    end
                end
                StUnload: begin
                    if (out_hs && (cnt_q != 4'd7)) begin
                        out_re_q <= ram_re[cnt_q[2:0] + 3'd1];
                        out_im_q <= ram_im[cnt_q[2:0] + 3'd1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fantasticfft_ifft8.sv
// Directed self-checking bench for fantasticfft_ifft8: impulse, constant, tone,
// backpressure, mid-frame resets and back-to-back frames.
module tb_fantasticfft_ifft8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [15:0] in_re, in_im, out_re, out_im;

    fantasticfft_ifft8 #(.WI(8), .WF(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int t_last, t_first, t_out_last;

    logic [15:0] src_re [8];
    logic [15:0] src_im [8];
    logic [15:0] exp_re [8];
    logic [15:0] exp_im [8];
    int          exp_tol [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_tol(input string tag, input logic [15:0] obs, input logic [15:0] expv,
                             input int tol);
        int d;
        checks++;
        d = int'($signed(obs)) - int'($signed(expv));
        assert (d >= -tol && d <= tol) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h +/-%0d", tag, obs, expv, tol);
        end
    endtask

    // kind: 0 impulse, 1 constant, 2 single tone at bin 1
    task automatic load_src(input int kind);
        for (int i = 0; i < 8; i++) begin
            src_im[i] = 16'h0000;
            case (kind)
                0:       src_re[i] = (i == 0) ? 16'h0100 : 16'h0000;
                1:       src_re[i] = 16'h0100;
                default: src_re[i] = (i == 1) ? 16'h0800 : 16'h0000;
            endcase
        end
    endtask

    task automatic load_exp(input int kind);
        for (int i = 0; i < 8; i++) begin
            exp_tol[i] = 0;
            exp_im[i]  = 16'h0000;
            case (kind)
                0:       exp_re[i] = 16'h0020;
                1:       exp_re[i] = (i == 0) ? 16'h0100 : 16'h0000;
                default: exp_re[i] = 16'h0000;
            endcase
        end
        if (kind == 2) begin
            exp_re[0] = 16'h0100; exp_im[0] = 16'h0000;
            exp_re[1] = 16'h00B5; exp_im[1] = 16'h00B5;
            exp_re[2] = 16'h0000; exp_im[2] = 16'h0100;
            exp_re[3] = 16'hFF4B; exp_im[3] = 16'h00B5;
            exp_re[4] = 16'hFF00; exp_im[4] = 16'h0000;
            exp_re[5] = 16'hFF4B; exp_im[5] = 16'hFF4B;
            exp_re[6] = 16'h0000; exp_im[6] = 16'hFF00;
            exp_re[7] = 16'h00B5; exp_im[7] = 16'hFF4B;
            exp_tol[1] = 1; exp_tol[3] = 1; exp_tol[5] = 1; exp_tol[7] = 1;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that took the last sample.
    task automatic send_frame(input int n, input bit hold);
        for (int i = 0; i < n; i++) begin
            int b;
            in_valid = 1'b1;
            in_re    = src_re[i];
            in_im    = src_im[i];
            b = 0;
            while (!in_ready && b < 400) begin
                @(posedge clk); #1;
                b++;
            end
            if (!in_ready) begin
                check("send_timeout", {31'd0, in_ready}, 32'd1);
                in_valid = 1'b0;
                return;
            end
            if (i == 0) t_first = cyc;
            t_last = cyc;
            @(posedge clk); #1;
        end
        if (!hold) in_valid = 1'b0;
    endtask

    // mode 0: out_ready always high; mode 1: out_ready high one cycle in three.
    task automatic recv_frame(input string nm, input int mode);
        int hs, k, budget;
        bit first, prev_stall;
        logic [15:0] pre_re, pre_im;
        logic pre_last;
        hs = 0; k = 0; budget = 0; first = 1'b1; prev_stall = 1'b0;
        pre_re = '0; pre_im = '0; pre_last = 1'b0;
        while (hs < 8 && budget < 300) begin
            out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            k++;
            if (out_valid) begin
                if (first) begin
                    check($sformatf("%s_latency", nm), 32'(cyc - t_last), 32'd13);
                    first = 1'b0;
                end
                if (prev_stall) begin
                    check($sformatf("%s_stall_re", nm), {16'd0, out_re}, {16'd0, pre_re});
                    check($sformatf("%s_stall_im", nm), {16'd0, out_im}, {16'd0, pre_im});
                    check($sformatf("%s_stall_last", nm), {31'd0, out_last}, {31'd0, pre_last});
                end
                if (mode == 1) check($sformatf("%s_in_ready", nm), {31'd0, in_ready}, 32'd0);
                if (out_ready) begin
                    check_tol($sformatf("%s_re[%0d]", nm, hs), out_re, exp_re[hs], exp_tol[hs]);
                    check_tol($sformatf("%s_im[%0d]", nm, hs), out_im, exp_im[hs], exp_tol[hs]);
                    check($sformatf("%s_last[%0d]", nm, hs), {31'd0, out_last},
                          (hs == 7) ? 32'd1 : 32'd0);
                    t_out_last = cyc;
                    hs++;
                end
                prev_stall = !out_ready;
                pre_re = out_re; pre_im = out_im; pre_last = out_last;
            end
            @(posedge clk); #1;
            budget++;
        end
        check($sformatf("%s_handshakes", nm), 32'(hs), 32'd8);
        if (hs == 8) begin
            check($sformatf("%s_done_valid", nm), {31'd0, out_valid}, 32'd0);
            check($sformatf("%s_done_ready", nm), {31'd0, in_ready}, 32'd1);
        end
        out_ready = 1'b0;
    endtask

    task automatic check_idle(input string nm);
        check($sformatf("%s_in_ready", nm), {31'd0, in_ready}, 32'd1);
        check($sformatf("%s_out_valid", nm), {31'd0, out_valid}, 32'd0);
        check($sformatf("%s_out_last", nm), {31'd0, out_last}, 32'd0);
        check($sformatf("%s_busy", nm), {31'd0, busy}, 32'd0);
        check($sformatf("%s_out_re", nm), {16'd0, out_re}, 32'd0);
        check($sformatf("%s_out_im", nm), {16'd0, out_im}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Impulse
        load_src(0); load_exp(0);
        send_frame(8, 1'b0);
        check("imp_busy", {31'd0, busy}, 32'd1);
        check("imp_in_ready_low", {31'd0, in_ready}, 32'd0);
        recv_frame("imp", 0);

        // Constant
        load_src(1); load_exp(1);
        send_frame(8, 1'b0);
        recv_frame("const", 0);

        // Single tone at bin 1
        load_src(2); load_exp(2);
        send_frame(8, 1'b0);
        recv_frame("tone", 0);

        // Backpressure
        load_src(0); load_exp(0);
        send_frame(8, 1'b0);
        recv_frame("bp", 1);

        // Reset after 5 input samples
        load_src(2);
        send_frame(5, 1'b0);
        #2 rst = 1'b1;
        #1 check_idle("rst_load");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        load_src(0); load_exp(0);
        send_frame(8, 1'b0);
        recv_frame("rst1", 0);

        // Reset in compute cycle 6
        load_src(2);
        send_frame(8, 1'b0);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_idle("rst_comp");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        load_src(0); load_exp(0);
        send_frame(8, 1'b0);
        recv_frame("rst2", 0);

        // Back-to-back with in_valid held high
        load_src(0); load_exp(0);
        send_frame(8, 1'b1);
        fork
            begin
                load_src(1);
                send_frame(8, 1'b0);
            end
            recv_frame("b2b1", 0);
        join
        check("b2b_accept", 32'(t_first), 32'(t_out_last + 1));
        load_exp(1);
        recv_frame("b2b2", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
